// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helpers for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int BCD_NIB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Number of decimal digits needed to print 2**w-1.
  function automatic int bcd_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        n = n + 1;
        v = v / 64'd10;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_iter_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  assign dig_o = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;

endmodule

// File: rtl/bin2bcd_iter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes on both the input word and the BCD result.
module bin2bcd_iter
  import bin2bcd_pkg::*;
#(
  parameter  int BIN_W     = 8,
  parameter  bit SIGNED_EN = 1'b0,
  localparam int DIGITS    = bcd_digits(BIN_W)
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iVALID,
  output logic                        oREADY,
  input  logic [BIN_W-1:0]            iBIN,
  output logic                        oVALID,
  input  logic                        iREADY,
  output logic [BCD_NIB*DIGITS-1:0]   oBCD,
  output logic                        oSIGN,
  output logic [1:0]                  oSTATE
);

  localparam int WORK_W = BCD_NIB * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  // Handshake rules: a word moves on any rising edge where iVALID && oREADY;
  // a result moves on any rising edge where oVALID && iREADY. oVALID, oBCD
  // and oSIGN hold steady until that result edge.

  bcd_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIN_W-1:0]    shift_q;
  logic [BIN_W-1:0]    shift_d;
  logic [WORK_W-1:0]   work_q;
  logic [WORK_W-1:0]   work_d;
  logic [WORK_W-1:0]   work_adj;
  logic                sign_q;
  logic [WORK_W-1:0]   bcd_q;
  logic                osign_q;
  logic [BIN_W-1:0]    mag;
  logic                in_neg;

  // Two's-complement magnitude; the most negative value wraps to itself,
  // which read as unsigned is exactly its magnitude.
  assign in_neg = SIGNED_EN && iBIN[BIN_W-1];
  assign mag    = in_neg ? ((~iBIN) + BIN_W'(1)) : iBIN;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dig_i (work_q[g*BCD_NIB +: BCD_NIB]),
      .dig_o (work_adj[g*BCD_NIB +: BCD_NIB])
    );
  end

  assign work_d  = {work_adj[WORK_W-2:0], shift_q[BIN_W-1]};
  assign shift_d = {shift_q[BIN_W-2:0], 1'b0};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      work_q  <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      osign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iVALID) begin
            shift_q <= mag;
            work_q  <= '0;
            cnt_q   <= CNT_W'(BIN_W);
            sign_q  <= in_neg;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q  <= work_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            bcd_q   <= work_d;
            osign_q <= sign_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (iREADY) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oREADY = (state_q == IDLE);
  assign oVALID = (state_q == DONE);
  assign oBCD   = bcd_q;
  assign oSIGN  = osign_q;
  assign oSTATE = state_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed and randomized checks of bin2bcd_iter at 8u, 8s, 16u and 32u widths
// against a decimal-arithmetic reference model.
module tb_bin2bcd_iter;

  logic        clk;
  logic        rst;
  logic [3:0]  vld;
  logic [3:0]  rdy_in;
  logic [3:0]  ordy;
  logic [3:0]  ovld;
  logic [3:0]  osgn;
  logic [31:0] bin [4];
  logic [39:0] bcd [4];
  logic [1:0]  ost [4];
  logic [11:0] b0;
  logic [11:0] b1;
  logic [19:0] b2;
  logic [39:0] b3;

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_iter #(.BIN_W(8), .SIGNED_EN(1'b0)) u8u (
    .iCLK(clk), .iRST(rst), .iVALID(vld[0]), .oREADY(ordy[0]), .iBIN(bin[0][7:0]),
    .oVALID(ovld[0]), .iREADY(rdy_in[0]), .oBCD(b0), .oSIGN(osgn[0]), .oSTATE(ost[0]));
  bin2bcd_iter #(.BIN_W(8), .SIGNED_EN(1'b1)) u8s (
    .iCLK(clk), .iRST(rst), .iVALID(vld[1]), .oREADY(ordy[1]), .iBIN(bin[1][7:0]),
    .oVALID(ovld[1]), .iREADY(rdy_in[1]), .oBCD(b1), .oSIGN(osgn[1]), .oSTATE(ost[1]));
  bin2bcd_iter #(.BIN_W(16), .SIGNED_EN(1'b0)) u16 (
    .iCLK(clk), .iRST(rst), .iVALID(vld[2]), .oREADY(ordy[2]), .iBIN(bin[2][15:0]),
    .oVALID(ovld[2]), .iREADY(rdy_in[2]), .oBCD(b2), .oSIGN(osgn[2]), .oSTATE(ost[2]));
  bin2bcd_iter #(.BIN_W(32), .SIGNED_EN(1'b0)) u32 (
    .iCLK(clk), .iRST(rst), .iVALID(vld[3]), .oREADY(ordy[3]), .iBIN(bin[3]),
    .oVALID(ovld[3]), .iREADY(rdy_in[3]), .oBCD(b3), .oSIGN(osgn[3]), .oSTATE(ost[3]));

  assign bcd[0] = {28'd0, b0};
  assign bcd[1] = {28'd0, b1};
  assign bcd[2] = {20'd0, b2};
  assign bcd[3] = b3;

  function automatic int wof(input int idx);
    case (idx)
      0, 1:    return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic bit sof(input int idx);
    return (idx == 1);
  endfunction

  // Reference: magnitude by modular arithmetic, digits by repeated /10.
  task automatic ref_model(input int w, input bit s, input logic [31:0] v,
                           output logic [39:0] b, output logic sg);
    longint unsigned full;
    longint unsigned m;
    full = 64'd1 << w;
    m    = 64'(v) & (full - 64'd1);
    sg   = s && (m >= full / 64'd2);
    if (sg) m = full - m;
    b = '0;
    for (int d = 0; d < 10; d++) begin
      b[d*4 +: 4] = 4'(m % 64'd10);
      m = m / 64'd10;
    end
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int idx, input logic [31:0] val, input int hold);
    int          cyc;
    logic [39:0] exp_bcd;
    logic        exp_sgn;
    logic        rdy_bad;
    logic        stable_bad;
    ref_model(wof(idx), sof(idx), val, exp_bcd, exp_sgn);
    cyc = 0;
    while (!ordy[idx] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_wait", {39'd0, ordy[idx]}, 40'd1);
    vld[idx] = 1'b1;
    bin[idx] = val;
    @(posedge clk);
    @(negedge clk);
    vld[idx] = 1'b0;
    bin[idx] = $urandom;
    cyc = 0;
    rdy_bad = 1'b0;
    while (!ovld[idx] && cyc < 200) begin
      if (ordy[idx]) rdy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 40'(cyc), 40'(wof(idx)));
    chk("ready_busy", {39'd0, rdy_bad | ordy[idx]}, 40'd0);
    chk("bcd", bcd[idx], exp_bcd);
    chk("sign", {39'd0, osgn[idx]}, {39'd0, exp_sgn});
    stable_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      vld[idx] = 1'($urandom_range(0, 1));
      bin[idx] = $urandom;
      @(negedge clk);
      if (!ovld[idx] || bcd[idx] !== exp_bcd || osgn[idx] !== exp_sgn || ordy[idx])
        stable_bad = 1'b1;
    end
    vld[idx] = 1'b0;
    chk("hold_stable", {39'd0, stable_bad}, 40'd0);
    rdy_in[idx] = 1'b1;
    @(negedge clk);
    rdy_in[idx] = 1'b0;
    chk("release_valid", {39'd0, ovld[idx]}, 40'd0);
    chk("release_ready", {39'd0, ordy[idx]}, 40'd1);
    chk("held_bcd", bcd[idx], exp_bcd);
  endtask

  initial begin
    int          cyc;
    int          idx;
    logic [31:0] val;
    logic [31:0] corner [6];

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    vld         = '1;
    rdy_in      = '0;
    for (int i = 0; i < 4; i++) bin[i] = 32'hFFFF_FFFF;

    // Reset state, with iVALID high to show it is ignored during reset.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", {39'd0, ovld[i]}, 40'd0);
      chk("rst_bcd", bcd[i], 40'd0);
      chk("rst_sign", {39'd0, osgn[i]}, 40'd0);
    end
    vld = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {36'd0, ordy}, 40'hF);

    run(0, 32'd255, 0);
    run(0, 32'd0,   1);
    run(0, 32'd99,  2);
    run(0, 32'd170, 20);
    run(1, 32'h80,  0);
    run(1, 32'hFF,  3);
    run(1, 32'h7F,  1);
    run(1, 32'h00,  0);
    run(2, 32'hFFFF, 2);
    run(3, 32'hFFFF_FFFF, 2);
    run(3, 32'd0, 0);

    // Throughput with iVALID and iREADY tied high.
    rdy_in[0] = 1'b1;
    vld[0]    = 1'b1;
    bin[0]    = 32'd77;
    cyc = 0;
    while (!ordy[0] && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    cyc = 1;
    while (!ordy[0] && cyc < 50) begin @(negedge clk); cyc++; end
    chk("throughput", 40'(cyc), 40'd10);
    vld[0] = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (!ordy[0] && cyc < 50) begin @(negedge clk); cyc++; end
    rdy_in[0] = 1'b0;

    // Make sure the 8u and 32u outputs hold nonzero results before reset.
    run(0, 32'd170, 0);
    run(3, 32'd123456789, 0);

    // Asynchronous reset three cycles into a conversion.
    vld[0] = 1'b1;
    bin[0] = 32'd200;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {39'd0, ovld[0]}, 40'd0);
    chk("arst_bcd", bcd[0], 40'd0);
    chk("arst_bcd32", bcd[3], 40'd0);
    chk("arst_state", {38'd0, ost[0]}, 40'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_no_stale", {36'd0, ovld}, 40'd0);
    run(0, 32'd42, 1);

    corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0080};
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 3));
      val = (n % 5 == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(idx, val, int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
